// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode codes, FSM state type and illegal-opcode helpers
// for the alu_seq_core block and its sub-modules.
package alu_seq_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_MUL   = 4'd0;
   localparam logic [OP_W-1:0] OP_SNE   = 4'd1;
   localparam logic [OP_W-1:0] OP_SLT   = 4'd2;
   localparam logic [OP_W-1:0] OP_SEQ   = 4'd3;
   localparam logic [OP_W-1:0] OP_NOR   = 4'd4;
   localparam logic [OP_W-1:0] OP_PASSB = 4'd5;
   localparam logic [OP_W-1:0] OP_ROL   = 4'd6;
   localparam logic [OP_W-1:0] OP_OR    = 4'd7;
   localparam logic [OP_W-1:0] OP_SLL   = 4'd8;
   localparam logic [OP_W-1:0] OP_XOR   = 4'd9;
   localparam logic [OP_W-1:0] OP_MAX   = 4'd10;
   localparam logic [OP_W-1:0] OP_MIN   = 4'd11;

   // Codes from here up to 15 are reserved and flagged as errors.
   localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 4'd12;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      DONE     = 2'd2
   } state_t;

   function automatic logic is_illegal(input logic [OP_W-1:0] op);
      return (op >= OP_ILLEGAL_MIN);
   endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// alu_shift_add_mul: iterative shift-add multiplier, one partial product per
// cycle over WIDTH cycles. Built only when ALU_SEQ_MUL_EN is defined.
// Ports:
//   clk, reset     : clock, async active-high reset
//   start          : pulse, captures a/b and begins a multiply
//   a, b           : operands (WIDTH bits)
//   busy           : registered, multiply in progress
//   done_c         : combinational, high in the cycle whose closing edge
//                    retires the final partial product
//   product_c      : combinational 2*WIDTH product, valid while done_c is high
`ifdef ALU_SEQ_MUL_EN
module alu_shift_add_mul #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done_c,
   output logic [2*WIDTH-1:0] product_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam int unsigned PW    = 2 * WIDTH;

   logic [CNT_W-1:0] cnt;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [PW-1:0]    partial_c;

   // Next accumulator value; on the last step it is the finished product.
   always_comb begin
      partial_c = '0;
      if (mplier[0]) partial_c = mcand;
      product_c = acc + partial_c;
      done_c    = busy && (cnt == CNT_W'(WIDTH - 1));
   end

   // Step counter runs 0..WIDTH-1 and parks at 0 when the multiply retires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (busy) begin
         acc    <= product_c;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done_c) begin
            busy <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt  <= cnt + CNT_W'(1);
         end
      end
   end

endmodule
`endif

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked 12-operation ALU with flags. Single-cycle ops
// return one cycle after acceptance; MUL uses an iterative shift-add unit.
// Optional feature macro: ALU_SEQ_MUL_EN (when undefined, MUL is treated as
// an illegal opcode with single-cycle latency and no multiplier is built).
// Ports:
//   clk, reset            : clock, async active-high reset
//   in_valid / in_ready   : request handshake (in_ready combinational)
//   opcode, input1, input2, shiftValue : request payload, latched on accept
//   out_valid / out_ready : result handshake
//   result, carryFlag, zeroFlag, errFlag : registered result and flags
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHIFT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    opcode,
   input  logic [WIDTH-1:0]   input1,
   input  logic [WIDTH-1:0]   input2,
   input  logic [SHIFT_W-1:0] shiftValue,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               carryFlag,
   output logic               zeroFlag,
   output logic               errFlag
);

   localparam logic [SHIFT_W:0] WIDTH_SH = (SHIFT_W + 1)'(WIDTH);

   state_t           state;
   logic             accept;
   logic             is_mul_c;
   logic [WIDTH-1:0] res_c;
   logic             carry_c;
   logic             err_c;
   logic [WIDTH-1:0] sll_c;
   logic [WIDTH-1:0] rol_c;
   logic [SHIFT_W:0] rsh_c;

   // DONE accepts a new request only on the edge the old result is taken.
   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
   logic               mul_busy;
   logic               mul_done_c;
   logic [2*WIDTH-1:0] mul_product_c;

   assign is_mul_c = (opcode == OP_MUL);

   alu_shift_add_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && is_mul_c),
      .a         (input1),
      .b         (input2),
      .busy      (mul_busy),
      .done_c    (mul_done_c),
      .product_c (mul_product_c)
   );
`else
   assign is_mul_c = 1'b0;
`endif

   // Single-cycle datapath, evaluated on the live request inputs.
   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      err_c   = is_illegal(opcode);
      // Right-shift by WIDTH yields 0, so shiftValue=0 degenerates cleanly.
      rsh_c   = WIDTH_SH - {1'b0, shiftValue};
      sll_c   = input1 << shiftValue;
      rol_c   = sll_c | (input1 >> rsh_c);
      case (opcode)
`ifndef ALU_SEQ_MUL_EN
         OP_MUL:   err_c = 1'b1;
`endif
         OP_SNE:   res_c = WIDTH'(input1 != input2);
         OP_SLT:   res_c = WIDTH'($signed(input1) < $signed(input2));
         OP_SEQ:   res_c = WIDTH'(input1 == input2);
         OP_NOR:   res_c = ~(input1 | input2);
         OP_PASSB: res_c = input2;
         OP_ROL: begin
            res_c   = rol_c;
            carry_c = (shiftValue != '0) && rol_c[0];
         end
         OP_OR:    res_c = input1 | input2;
         OP_SLL: begin
            // Bit 0 of the rotate is A[WIDTH-shiftValue], the last bit out.
            res_c   = sll_c;
            carry_c = (shiftValue != '0) && rol_c[0];
         end
         OP_XOR:   res_c = input1 ^ input2;
         OP_MAX:   res_c = (input1 > input2) ? input1 : input2;
         OP_MIN:   res_c = (input1 < input2) ? input1 : input2;
         default:  res_c = '0;
      endcase
   end

   // Control FSM with registered result and flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         carryFlag <= 1'b0;
         zeroFlag  <= 1'b1;
         errFlag   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  if (is_mul_c) begin
                     state     <= MUL_BUSY;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= res_c;
                     carryFlag <= carry_c;
                     zeroFlag  <= (res_c == '0);
                     errFlag   <= err_c;
                  end
               end else if ((state == DONE) && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL_BUSY: begin
               if (mul_busy && mul_done_c) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= mul_product_c[WIDTH-1:0];
                  carryFlag <= |mul_product_c[2*WIDTH-1:WIDTH];
                  zeroFlag  <= (mul_product_c[WIDTH-1:0] == '0);
                  errFlag   <= 1'b0;
               end
            end
`endif
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed self-checking bench for alu_seq_core, WIDTH=32.
// MUL expectations follow ALU_SEQ_MUL_EN (iterative multiply when defined,
// illegal single-cycle opcode otherwise).
module tb_alu_seq_core;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    opcode = 4'd0;
   logic [W-1:0]  input1 = '0;
   logic [W-1:0]  input2 = '0;
   logic [4:0]    shiftValue = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          carryFlag;
   logic          zeroFlag;
   logic          errFlag;

   int n_checks = 0;
   int n_fail   = 0;

   alu_seq_core #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .input1     (input1),
      .input2     (input2),
      .shiftValue (shiftValue),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .carryFlag  (carryFlag),
      .zeroFlag   (zeroFlag),
      .errFlag    (errFlag)
   );

   always #5 clk = ~clk;

   // Present one request for a single edge, then drop in_valid.
   task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh);
      @(negedge clk);
      opcode = op; input1 = a; input2 = b; shiftValue = sh; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
      n_checks++; if (carryFlag !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carryFlag); end
      n_checks++; if (zeroFlag !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zeroFlag); end
      n_checks++; if (errFlag !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", errFlag); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_mul;
      int cycles;
      out_ready = 1'b1;
      issue(4'd0, 32'h0001_0000, 32'h0001_0000, 5'd0);
`ifdef ALU_SEQ_MUL_EN
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy_in_ready got %b want 0", in_ready); end
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
      end
      n_checks++; if (cycles !== 32) begin n_fail++; $display("FAIL mul_latency got %0d want 32", cycles); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL mul_result got %h want 0", result); end
      n_checks++; if (carryFlag !== 1'b1) begin n_fail++; $display("FAIL mul_carry got %b want 1", carryFlag); end
      n_checks++; if (zeroFlag !== 1'b1) begin n_fail++; $display("FAIL mul_zero got %b want 1", zeroFlag); end
      n_checks++; if (errFlag !== 1'b0) begin n_fail++; $display("FAIL mul_err got %b want 0", errFlag); end
      issue(4'd0, 32'h0000_1234, 32'h0000_0010, 5'd0);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
      end
      n_checks++; if (result !== 32'h0001_2340) begin n_fail++; $display("FAIL mul2_result got %h want 00012340", result); end
      n_checks++; if (carryFlag !== 1'b0) begin n_fail++; $display("FAIL mul2_carry got %b want 0", carryFlag); end
`else
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_off_valid got %b want 1", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL mul_off_result got %h want 0", result); end
      n_checks++; if (errFlag !== 1'b1) begin n_fail++; $display("FAIL mul_off_err got %b want 1", errFlag); end
      n_checks++; if (zeroFlag !== 1'b1) begin n_fail++; $display("FAIL mul_off_zero got %b want 1", zeroFlag); end
      n_checks++; if (carryFlag !== 1'b0) begin n_fail++; $display("FAIL mul_off_carry got %b want 0", carryFlag); end
`endif
   endtask

   task automatic test_shift;
      out_ready = 1'b1;
      issue(4'd8, 32'h8000_0001, 32'h0, 5'd1);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sll_valid got %b want 1", out_valid); end
      n_checks++; if (result !== 32'h0000_0002) begin n_fail++; $display("FAIL sll_result got %h want 00000002", result); end
      n_checks++; if (carryFlag !== 1'b1) begin n_fail++; $display("FAIL sll_carry got %b want 1", carryFlag); end
      issue(4'd6, 32'h8000_0001, 32'h0, 5'd1);
      n_checks++; if (result !== 32'h0000_0003) begin n_fail++; $display("FAIL rol_result got %h want 00000003", result); end
      n_checks++; if (carryFlag !== 1'b1) begin n_fail++; $display("FAIL rol_carry got %b want 1", carryFlag); end
      issue(4'd8, 32'h8000_0001, 32'h0, 5'd0);
      n_checks++; if (result !== 32'h8000_0001) begin n_fail++; $display("FAIL sll0_result got %h want 80000001", result); end
      n_checks++; if (carryFlag !== 1'b0) begin n_fail++; $display("FAIL sll0_carry got %b want 0", carryFlag); end
      issue(4'd8, 32'hE000_0001, 32'h0, 5'd4);
      n_checks++; if (result !== 32'h0000_0010) begin n_fail++; $display("FAIL sll4_result got %h want 00000010", result); end
      n_checks++; if (carryFlag !== 1'b0) begin n_fail++; $display("FAIL sll4_carry got %b want 0", carryFlag); end
      issue(4'd6, 32'h1234_5678, 32'h0, 5'd8);
      n_checks++; if (result !== 32'h3456_7812) begin n_fail++; $display("FAIL rol8_result got %h want 34567812", result); end
      n_checks++; if (carryFlag !== 1'b0) begin n_fail++; $display("FAIL rol8_carry got %b want 0", carryFlag); end
   endtask

   task automatic test_compare;
      out_ready = 1'b1;
      issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
      n_checks++; if (result !== 32'h1) begin n_fail++; $display("FAIL slt_result got %h want 1", result); end
      issue(4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
      n_checks++; if (result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL max_result got %h want ffffffff", result); end
      n_checks++; if (zeroFlag !== 1'b0) begin n_fail++; $display("FAIL max_zero got %b want 0", zeroFlag); end
      issue(4'd11, 32'h0000_0003, 32'h0000_0009, 5'd0);
      n_checks++; if (result !== 32'h3) begin n_fail++; $display("FAIL min_result got %h want 3", result); end
      issue(4'd3, 32'h0000_0007, 32'h0000_0007, 5'd0);
      n_checks++; if (result !== 32'h1) begin n_fail++; $display("FAIL seq_result got %h want 1", result); end
      issue(4'd1, 32'h0000_0007, 32'h0000_0007, 5'd0);
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL sne_result got %h want 0", result); end
      n_checks++; if (zeroFlag !== 1'b1) begin n_fail++; $display("FAIL sne_zero got %b want 1", zeroFlag); end
      issue(4'd5, 32'h1111_1111, 32'h0000_ABCD, 5'd0);
      n_checks++; if (result !== 32'h0000_ABCD) begin n_fail++; $display("FAIL passb_result got %h want 0000abcd", result); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      input1 = 32'hF0F0_1234; input2 = 32'h0FF0_00FF; shiftValue = 5'd0;
      opcode = 4'd9; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || result !== 32'hFF00_12CB) begin n_fail++; $display("FAIL b2b_xor got v=%b %h want v=1 ff0012cb", out_valid, result); end
      @(negedge clk); opcode = 4'd7;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || result !== 32'hFFF0_12FF) begin n_fail++; $display("FAIL b2b_or got v=%b %h want v=1 fff012ff", out_valid, result); end
      @(negedge clk); opcode = 4'd4;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || result !== 32'h000F_ED00) begin n_fail++; $display("FAIL b2b_nor got v=%b %h want v=1 000fed00", out_valid, result); end
      @(negedge clk); out_ready = 1'b0; opcode = 4'd9; input1 = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++; if (result !== 32'h000F_ED00 || out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_result cyc %0d got v=%b %h want v=1 000fed00", i, out_valid, result); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc %0d got %b want 0", i, in_ready); end
      end
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b want 0", out_valid); end
   endtask

   task automatic test_illegal;
      out_ready = 1'b1;
      issue(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_valid got %b want 1", out_valid); end
      n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL illegal_result got %h want 0", result); end
      n_checks++; if (errFlag !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b want 1", errFlag); end
      n_checks++; if (zeroFlag !== 1'b1) begin n_fail++; $display("FAIL illegal_zero got %b want 1", zeroFlag); end
      issue(4'd7, 32'h0000_0001, 32'h0000_0002, 5'd0);
      n_checks++; if (errFlag !== 1'b0 || result !== 32'h3) begin n_fail++; $display("FAIL legal_after_err got err=%b %h want err=0 3", errFlag, result); end
   endtask

   task automatic test_reset_mid_mul;
      int seen;
      out_ready = 1'b0;
      issue(4'd0, 32'h0000_1234, 32'h0000_5678, 5'd0);
      repeat (9) @(posedge clk);
      #1;
`ifdef ALU_SEQ_MUL_EN
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_mul_busy got rdy=%b v=%b want 0 0", in_ready, out_valid); end
`else
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_done_hold got %b want 1", out_valid); end
`endif
      @(negedge clk); reset = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_handshake got v=%b rdy=%b want 0 1", out_valid, in_ready); end
      n_checks++; if (result !== 32'h0 || zeroFlag !== 1'b1 || carryFlag !== 1'b0 || errFlag !== 1'b0) begin n_fail++; $display("FAIL abort_outputs got %h z=%b c=%b e=%b want 0 1 0 0", result, zeroFlag, carryFlag, errFlag); end
      @(negedge clk); reset = 1'b0; out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL post_reset_valid got %0d cycles want 0", seen); end
   endtask

   initial begin
      test_reset;
      test_mul;
      test_shift;
      test_compare;
      test_back_to_back;
      test_illegal;
      test_reset_mid_mul;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, handshaked successor to the generated combinational ALUs. It executes the same 12-operation set plus flag generation over a configurable data width. Single-cycle operations return one cycle after acceptance; MUL runs on an iterative shift-add unit. The block sits between an operand-issue stage and a result-writeback stage, and uses valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 32: data width. Must be a power of two and ≥ 8.
- `SHIFT_W`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk`  input  1: single clock, rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `in_valid`  input  1: operation request.
- `in_ready`  output  1: block can accept a request this cycle.
- `opcode`  input  4: operation select. Codes are listed in the package.
- `input1`  input  WIDTH: operand A.
- `input2`  input  WIDTH: operand B.
- `shiftValue`  input  SHIFT_W: shift/rotate amount.
- `out_valid`  output  1: result and flags are valid.
- `out_ready`  input  1: downstream accepts the result.
- `result`  output  WIDTH: registered result.
- `carryFlag`  output  1: registered carry/overflow.
- `zeroFlag`  output  1: registered, equals (result == 0).
- `errFlag`  output  1: registered, illegal or disabled opcode.

## Operation
- Opcodes: MUL=0, SNE=1, SLT=2, SEQ=3, NOR=4, PASSB=5, ROL=6, OR=7, SLL=8, XOR=9, MAX=10, MIN=11. Codes 12–15 are illegal.
- A request is accepted on a rising edge where `in_valid && in_ready`. Operands, opcode and `shiftValue` are latched at that edge; later input changes are ignored.
- States:
  - IDLE. `in_ready`=1.
    - Accept a MUL → MUL_BUSY.
    - Accept any other opcode → DONE.
  - MUL_BUSY. `in_ready`=0. One partial product per cycle over WIDTH cycles, then → DONE.
  - DONE. `out_valid`=1 and `in_ready`=`out_ready`.
    - `out_ready` low: hold result and flags stable.
    - `out_ready` high with a new acceptance on the same edge: go to MUL_BUSY or DONE per the new opcode. Back-to-back single-cycle ops therefore sustain one result per cycle.
    - `out_ready` high with no new acceptance → IDLE.
- Result rules:
  - MUL: low WIDTH bits of the product.
  - SNE, SEQ, SLT: result is {WIDTH-1 zeros, bit}. SLT is a signed compare.
  - NOR: ~(A|B). OR: A|B. XOR: A^B. PASSB: B.
  - SLL: A << shiftValue. ROL: A rotated left by shiftValue.
  - MAX and MIN use unsigned compare. On equal operands the result is B.
  - Illegal opcode: result 0, `errFlag`=1.
- `carryFlag` rules:
  - MUL: 1 if the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - SLL: the last bit shifted out, i.e. A[WIDTH-shiftValue]. It is 0 when shiftValue=0.
  - ROL: `result[0]` when shiftValue≠0, otherwise 0.
  - All other opcodes: 0.
- `errFlag` is 0 for all legal opcodes.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `carryFlag`=0, `zeroFlag`=1, `errFlag`=0.
- Single-cycle op accepted at edge N: `out_valid` rises after edge N.
- MUL accepted at edge N: `out_valid` rises after edge N+WIDTH. That is 32 cycles of `in_ready`=0 for WIDTH=32.
- Outputs are registered and change only on acceptance or completion. They hold while `out_valid && !out_ready`.
- Reset asserted mid-MUL or in DONE: the operation is aborted immediately and all outputs take their reset values. No result is produced after reset releases.
- The multiply counter is `$clog2(WIDTH)+1` bits and counts from 0 to WIDTH-1. It has no wrap beyond that range.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL uses the iterative multiplier as specified.
- `ALU_SEQ_MUL_EN` undefined:
  - The multiplier and MUL_BUSY are not built.
  - MUL behaves as an illegal opcode: result 0, `errFlag`=1, single-cycle latency.

## Structure
- Package `alu_seq_pkg` holds:
  - the opcode localparams;
  - the state enum typedef (IDLE, MUL_BUSY, DONE);
  - the illegal-opcode range constant.
- Sub-module `alu_shift_add_mul`, parametrised by WIDTH:
  - inputs: start pulse and operands;
  - outputs: busy, done and the 2·WIDTH product;
  - compiled only under `ALU_SEQ_MUL_EN`.
- All single-cycle datapath logic stays in the top module.

## Test plan
All scenarios use WIDTH=32.
- Reset: during `reset`=1, all outputs are at reset values, including `zeroFlag`=1 and `in_ready`=1.
- MUL 0x0001_0000 × 0x0001_0000:
  - `out_valid` arrives 32 cycles after acceptance;
  - result=0, `carryFlag`=1, `zeroFlag`=1.
- SLL A=0x8000_0001, shift=1: result=0x0000_0002, `carryFlag`=1. ROL with the same operands: result=0x0000_0003, `carryFlag`=1.
- SLT A=0xFFFF_FFFF, B=1: result=1. MAX with the same operands: result=0xFFFF_FFFF.
- Back-to-back XOR, OR, NOR with `out_ready` tied high:
  - one result per cycle;
  - then hold `out_ready` low for 3 cycles: result stable, `in_ready`=0.
- Opcode 13 → result 0, `errFlag`=1. Reset pulsed 10 cycles into a MUL: outputs return to reset values and no `out_valid` follows.
